// File: rtl/ps2_mouse_packet_ctrl_if.sv
// rtl/ps2_mouse_packet_ctrl_if.sv - framed-byte bus from the PS/2 byte receiver
interface ps2_mouse_packet_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  modport master (output byte_valid, output byte_data, output frame_err);
  modport slave  (input  byte_valid, input  byte_data, input  frame_err);
endinterface

// File: rtl/ps2_mouse_packet_ctrl.sv
// rtl/ps2_mouse_packet_ctrl.sv - PS/2 mouse packet sequencer with clamped cursor
// Optional 4-byte wheel packets with PS2_MOUSE_WHEEL_EN.
module ps2_mouse_packet_ctrl #(
  parameter int H_MAX          = 639,
  parameter int V_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_mouse_packet_ctrl_if.slave  rx,
  output logic [9:0]              mouse_x,
  output logic [9:0]              mouse_y,
  output logic                    left_click,
  output logic                    right_click,
  output logic                    middle_click,
  output logic                    pkt_valid,
  output logic                    sync_err,
  output logic [3:0]              wheel_z
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;
`ifdef PS2_MOUSE_WHEEL_EN
  localparam logic [1:0] WAIT_B3 = 2'd3;
`endif

  logic [1:0]    state_q, state_d;
  // hdr_q = {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}
  logic [6:0]    hdr_q, hdr_d;
  logic [7:0]    xb_q, xb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          pkt_q, pkt_d, err_q, err_d;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0]    yb_q, yb_d;
  logic [3:0]    wz_q, wz_d;
`endif

  logic [7:0]        y_byte;
  logic signed [11:0] dx, dy, x_sum, y_sum;
  logic [9:0]        x_apply, y_apply;

  always_comb begin
`ifdef PS2_MOUSE_WHEEL_EN
    y_byte = yb_q;
`else
    y_byte = rx.byte_data;
`endif
    dx    = $signed({{4{hdr_q[3]}}, xb_q});
    dy    = $signed({{4{hdr_q[4]}}, y_byte});
    x_sum = $signed({2'b00, x_q}) + dx;
    // Device +Y is up, screen Y grows downward.
    y_sum = $signed({2'b00, y_q}) - dy;

    if (hdr_q[5])                           x_apply = x_q;
    else if (x_sum[11])                     x_apply = 10'd0;
    else if (x_sum[10:0] > 11'(H_MAX))      x_apply = 10'(H_MAX);
    else                                    x_apply = x_sum[9:0];

    if (hdr_q[6])                           y_apply = y_q;
    else if (y_sum[11])                     y_apply = 10'd0;
    else if (y_sum[10:0] > 11'(V_MAX))      y_apply = 10'(V_MAX);
    else                                    y_apply = y_sum[9:0];
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    xb_d    = xb_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    pkt_d   = 1'b0;
    err_d   = 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
    yb_d    = yb_q;
    wz_d    = wz_q;
`endif

    if (rx.frame_err) begin
      state_d = WAIT_B0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else if (rx.byte_valid) begin
      cnt_d = '0;
      case (state_q)
        WAIT_B0: begin
          if (rx.byte_data[3]) begin
            hdr_d   = {rx.byte_data[7:4], rx.byte_data[2:0]};
            state_d = WAIT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
        WAIT_B1: begin
          xb_d    = rx.byte_data;
          state_d = WAIT_B2;
        end
`ifdef PS2_MOUSE_WHEEL_EN
        WAIT_B2: begin
          yb_d    = rx.byte_data;
          state_d = WAIT_B3;
        end
        WAIT_B3: begin
          x_d     = x_apply;
          y_d     = y_apply;
          btn_d   = hdr_q[2:0];
          wz_d    = rx.byte_data[3:0];
          pkt_d   = 1'b1;
          state_d = WAIT_B0;
        end
`else
        WAIT_B2: begin
          x_d     = x_apply;
          y_d     = y_apply;
          btn_d   = hdr_q[2:0];
          pkt_d   = 1'b1;
          state_d = WAIT_B0;
        end
`endif
        default: state_d = WAIT_B0;
      endcase
    end else if (state_q != WAIT_B0) begin
      // Idle gap inside a packet: the last allowed idle cycle aborts.
      if (cnt_q == CNT_LAST) begin
        state_d = WAIT_B0;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_B0;
      hdr_q   <= '0;
      xb_q    <= '0;
      cnt_q   <= '0;
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_INIT);
      btn_q   <= '0;
      pkt_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
      yb_q    <= '0;
      wz_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      xb_q    <= xb_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
`ifdef PS2_MOUSE_WHEEL_EN
      yb_q    <= yb_d;
      wz_q    <= wz_d;
`endif
    end
  end

  assign mouse_x      = x_q;
  assign mouse_y      = y_q;
  assign left_click   = btn_q[0];
  assign right_click  = btn_q[1];
  assign middle_click = btn_q[2];
  assign pkt_valid    = pkt_q;
  assign sync_err     = err_q;
`ifdef PS2_MOUSE_WHEEL_EN
  assign wheel_z      = wz_q;
`else
  assign wheel_z      = 4'd0;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// tb/tb_ps2_mouse_packet_ctrl.sv - randomized self-checking bench for ps2_mouse_packet_ctrl
module tb_ps2_mouse_packet_ctrl;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] mouse_x, mouse_y;
  logic       left_click, right_click, middle_click;
  logic       pkt_valid, sync_err;
  logic [3:0] wheel_z;

  ps2_mouse_packet_ctrl_if rx_if ();

  ps2_mouse_packet_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx_if),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .left_click   (left_click),
    .right_click  (right_click),
    .middle_click (middle_click),
    .pkt_valid    (pkt_valid),
    .sync_err     (sync_err),
    .wheel_z      (wheel_z)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int pkt_cnt = 0;
  int err_cnt = 0;

  int         mx, my;
  logic [2:0] mb;
  logic [3:0] mz;

  always @(negedge clk) begin
    if (!rst && pkt_valid) pkt_cnt++;
    if (!rst && sync_err)  err_cnt++;
  end

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_apply(logic [7:0] h, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    int dxi, dyi;
    dxi = h[4] ? int'(b1) - 256 : int'(b1);
    dyi = h[5] ? int'(b2) - 256 : int'(b2);
    if (!h[6]) mx = clampi(mx + dxi, 639);
    if (!h[7]) my = clampi(my - dyi, 479);
    mb = h[2:0];
`ifdef PS2_MOUSE_WHEEL_EN
    mz = b3[3:0];
`else
    mz = 4'd0 & b3[3:0];
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_if.byte_valid = 1'b0;
    rx_if.byte_data  = 8'h00;
    rx_if.frame_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mx = 320; my = 240; mb = 3'b000; mz = 4'd0;
  endtask

  task automatic send_byte(logic [7:0] b, logic v, logic fe);
    @(negedge clk);
    rx_if.byte_valid = v;
    rx_if.byte_data  = b;
    rx_if.frame_err  = fe;
    @(posedge clk);
    #1;
    rx_if.byte_valid = 1'b0;
    rx_if.frame_err  = 1'b0;
  endtask

  task automatic send_pkt(logic [7:0] h, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    send_byte(h, 1'b1, 1'b0);
    send_byte(b1, 1'b1, 1'b0);
    send_byte(b2, 1'b1, 1'b0);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(b3, 1'b1, 1'b0);
`endif
    model_apply(h, b1, b2, b3);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({mouse_x, mouse_y, left_click, right_click, middle_click, pkt_valid, sync_err, wheel_z} !==
        {10'd320, 10'd240, 3'b000, 2'b00, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset: x=%0d y=%0d btn=%b%b%b pkt=%b err=%b wz=%h want x=320 y=240 rest 0",
               mouse_x, mouse_y, middle_click, right_click, left_click, pkt_valid, sync_err, wheel_z);
    end
  endtask

  task automatic test_basic_move();
    int p0;
    do_reset();
    p0 = pkt_cnt;
    send_pkt(8'h09, 8'h0A, 8'h05, 8'h00);
    tests_run++;
    if ({pkt_valid, mouse_x, mouse_y, left_click, right_click} !== {1'b1, 10'd330, 10'd235, 2'b10}) begin
      tests_failed++;
      $display("FAIL basic_move: pkt=%b x=%0d y=%0d l=%b r=%b want pkt=1 x=330 y=235 l=1 r=0",
               pkt_valid, mouse_x, mouse_y, left_click, right_click);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (pkt_cnt - p0 !== 1 || pkt_valid !== 1'b0 || mouse_x !== 10'd330) begin
      tests_failed++;
      $display("FAIL basic_hold: pulses=%0d pkt=%b x=%0d want pulses=1 pkt=0 x=330", pkt_cnt - p0, pkt_valid, mouse_x);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    send_pkt(8'h18, 8'hF6, 8'h00, 8'h00);
    tests_run++;
    if (mouse_x !== 10'd310) begin
      tests_failed++;
      $display("FAIL neg_move: x=%0d want 310", mouse_x);
    end
    repeat (3) send_pkt(8'h08, 8'h7F, 8'h00, 8'h00);
    tests_run++;
    if (mouse_x !== 10'd639) begin
      tests_failed++;
      $display("FAIL clamp_xmax: x=%0d want 639", mouse_x);
    end
    repeat (2) send_pkt(8'h08, 8'h00, 8'h7F, 8'h00);
    tests_run++;
    if (mouse_y !== 10'd0) begin
      tests_failed++;
      $display("FAIL clamp_y0: y=%0d want 0", mouse_y);
    end
  endtask

  task automatic test_resync();
    int e0;
    do_reset();
    e0 = err_cnt;
    send_byte(8'h00, 1'b1, 1'b0);
    send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 1 || mouse_x !== 10'd321 || mouse_y !== 10'd239) begin
      tests_failed++;
      $display("FAIL resync: errs=%0d x=%0d y=%0d want errs=1 x=321 y=239", err_cnt - e0, mouse_x, mouse_y);
    end
  endtask

  task automatic test_timeout();
    int e0, p0;
    do_reset();
    e0 = err_cnt;
    send_byte(8'h08, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    repeat (T + 3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 1 || mouse_x !== 10'd320) begin
      tests_failed++;
      $display("FAIL timeout_abort: errs=%0d x=%0d want errs=1 x=320", err_cnt - e0, mouse_x);
    end
    send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
    tests_run++;
    if (mouse_x !== 10'd321 || mouse_y !== 10'd239) begin
      tests_failed++;
      $display("FAIL timeout_recover: x=%0d y=%0d want x=321 y=239", mouse_x, mouse_y);
    end
    e0 = err_cnt;
    p0 = pkt_cnt;
    send_byte(8'h08, 1'b1, 1'b0);
    repeat (T - 1) @(posedge clk);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(8'h00, 1'b1, 1'b0);
`endif
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 0 || pkt_cnt - p0 !== 1 || mouse_x !== 10'd323) begin
      tests_failed++;
      $display("FAIL timeout_edge: errs=%0d pkts=%0d x=%0d want errs=0 pkts=1 x=323",
               err_cnt - e0, pkt_cnt - p0, mouse_x);
    end
  endtask

  task automatic test_overflow_frame_err();
    int e0, p0;
    do_reset();
    send_pkt(8'h48, 8'h10, 8'h10, 8'h00);
    tests_run++;
    if (mouse_x !== 10'd320 || mouse_y !== 10'd224) begin
      tests_failed++;
      $display("FAIL overflow: x=%0d y=%0d want x=320 y=224", mouse_x, mouse_y);
    end
    e0 = err_cnt;
    p0 = pkt_cnt;
    send_byte(8'h08, 1'b1, 1'b1);
    send_byte(8'h08, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 2 || pkt_cnt - p0 !== 1 || mouse_x !== 10'd321 || mouse_y !== 10'd223) begin
      tests_failed++;
      $display("FAIL frame_err: errs=%0d pkts=%0d x=%0d y=%0d want errs=2 pkts=1 x=321 y=223",
               err_cnt - e0, pkt_cnt - p0, mouse_x, mouse_y);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_byte(8'h08, 1'b1, 1'b0);
    send_byte(8'h05, 1'b1, 1'b0);
    do_reset();
    send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
    tests_run++;
    if (mouse_x !== 10'd321 || mouse_y !== 10'd239 || pkt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid: x=%0d y=%0d pkt=%b want x=321 y=239 pkt=1", mouse_x, mouse_y, pkt_valid);
    end
  endtask

`ifdef PS2_MOUSE_WHEEL_EN
  task automatic test_wheel();
    int p0;
    do_reset();
    p0 = pkt_cnt;
    send_byte(8'h08, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (pkt_cnt - p0 !== 0) begin
      tests_failed++;
      $display("FAIL wheel_early: pulses=%0d want 0", pkt_cnt - p0);
    end
    send_byte(8'hFF, 1'b1, 1'b0);
    tests_run++;
    if (pkt_valid !== 1'b1 || wheel_z !== 4'hF) begin
      tests_failed++;
      $display("FAIL wheel: pkt=%b wz=%h want pkt=1 wz=f", pkt_valid, wheel_z);
    end
  endtask
`endif

  task automatic test_random();
    int e0, p0, exp_err, exp_pkt;
    logic [7:0] h, b1, b2, b3;
    do_reset();
    e0 = err_cnt;
    p0 = pkt_cnt;
    exp_err = 0;
    exp_pkt = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        h = 8'($urandom) & 8'hF7;
        send_byte(h, 1'b1, 1'b0);
        exp_err++;
      end
      h  = 8'($urandom) | 8'h08;
      if ($urandom_range(0, 3) != 0) h[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      send_pkt(h, b1, b2, b3);
      exp_pkt++;
      tests_run++;
      if ({pkt_valid, mouse_x, mouse_y, middle_click, right_click, left_click, wheel_z} !==
          {1'b1, 10'(mx), 10'(my), mb, mz}) begin
        tests_failed++;
        $display("FAIL random[%0d] hdr=%h: pkt=%b x=%0d y=%0d btn=%b wz=%h want x=%0d y=%0d btn=%b wz=%h",
                 i, h, pkt_valid, mouse_x, mouse_y, {middle_click, right_click, left_click}, wheel_z,
                 mx, my, mb, mz);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== exp_err || pkt_cnt - p0 !== exp_pkt) begin
      tests_failed++;
      $display("FAIL random_counts: errs=%0d pkts=%0d want errs=%0d pkts=%0d",
               err_cnt - e0, pkt_cnt - p0, exp_err, exp_pkt);
    end
  endtask

  initial begin
    rx_if.byte_valid = 1'b0;
    rx_if.byte_data  = 8'h00;
    rx_if.frame_err  = 1'b0;
    test_reset();
    test_basic_move();
    test_clamp();
    test_resync();
    test_timeout();
    test_overflow_frame_err();
    test_reset_mid_packet();
`ifdef PS2_MOUSE_WHEEL_EN
    test_wheel();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_ctrl.md
# ps2_mouse_packet_ctrl

Packet-level controller between the PS/2 byte receiver and the VGA cursor/draw logic. Takes framed bytes from the receiver and sequences them into standard 3-byte mouse packets. Keeps byte alignment with the device, accumulates signed motion into an absolute cursor position clamped to the visible screen, and publishes button state. Recovers from misaligned, corrupted or stalled packets without a reset.

## Interface

Parameters:
- `H_MAX`, 639: largest legal `mouse_x`.
- `V_MAX`, 479: largest legal `mouse_y`.
- `X_INIT`, 320: `mouse_x` value after reset.
- `Y_INIT`, 240: `mouse_y` value after reset.
- `TIMEOUT_CYCLES`, 200000: maximum idle gap between bytes of one packet, in `clk` cycles (2 ms at 100 MHz).

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: reset. Synchronous, active-high.
- `byte_valid`, input, 1: one-cycle strobe; `byte_data` holds a complete received byte.
- `byte_data`, input, 8: received byte.
- `frame_err`, input, 1: one-cycle strobe; receiver saw a parity, start or stop error.
- `mouse_x`, output, 10: cursor X, range 0..`H_MAX`.
- `mouse_y`, output, 10: cursor Y, range 0..`V_MAX`. 0 is the top of the screen.
- `left_click`, output, 1: left button state.
- `right_click`, output, 1: right button state.
- `middle_click`, output, 1: middle button state.
- `pkt_valid`, output, 1: one-cycle strobe; a packet was applied.
- `sync_err`, output, 1: one-cycle strobe; a packet was discarded.
- `wheel_z`, output, 4: signed wheel delta of the last packet. Meaningful only with `PS2_MOUSE_WHEEL_EN`.

## Operation

**FSM states**
- `WAIT_B0`: waiting for the header byte.
  - `byte_valid` with `byte_data[3]==1`: latch the header, go to `WAIT_B1`.
  - `byte_valid` with `byte_data[3]==0`: byte dropped, `sync_err` pulses, stay in `WAIT_B0`.
- `WAIT_B1`: latch X byte, go to `WAIT_B2`.
- `WAIT_B2`: latch Y byte and apply the packet. Go to `WAIT_B0`, or to `WAIT_B3` when `PS2_MOUSE_WHEEL_EN` is defined.
- `WAIT_B3`: present only with the macro. Latch Z byte, apply the packet, go to `WAIT_B0`.

**Header byte fields**
- bit0 left, bit1 right, bit2 middle.
- bit4 X sign, bit5 Y sign.
- bit6 X overflow, bit7 Y overflow.

**Arithmetic**
- `dx = {xsign, byte1}`, 9-bit two's complement. `dy` is formed the same way from `ysign` and byte2.
- `x_new = x + dx`. `y_new = y - dy`, because device +Y means up.
- Both results are computed in 12-bit signed, then clamped: below 0 → 0; above `H_MAX` / `V_MAX` → that maximum.
- If an axis has its overflow bit set, that axis's delta is ignored. Buttons and the other axis are still applied.

**Abort conditions.** All of these discard the partial packet, pulse `sync_err` for 1 cycle, return to `WAIT_B0`, and leave the outputs unchanged.
- `frame_err` in any state.
- In any state other than `WAIT_B0`: no `byte_valid` for `TIMEOUT_CYCLES` consecutive cycles. The counter clears on every accepted byte.

**Simultaneous events**
- `frame_err` and `byte_valid` in the same cycle: `frame_err` wins and the byte is discarded.
- `byte_valid` in the same cycle the timeout expires: the byte is accepted, no timeout.

**Reset**
- Reset mid-packet discards the packet.

## Timing

- Reset values:
  - state `WAIT_B0`
  - `mouse_x=X_INIT`, `mouse_y=Y_INIT`
  - all clicks 0
  - `pkt_valid=0`, `sync_err=0`, `wheel_z=0`
  - timeout counter 0
- Latency: `mouse_x`, `mouse_y`, the clicks and `wheel_z` update on the clock edge after the final byte's `byte_valid` cycle. `pkt_valid` is high during that same next cycle.
- `sync_err` is asserted the cycle after the offending event.
- Back-to-back `byte_valid` on consecutive cycles is accepted. No backpressure exists: every strobe is consumed.
- Outputs are registered and held between packets.

## Configuration

- Macro: `PS2_MOUSE_WHEEL_EN`.
- Defined: 4-byte IntelliMouse packets.
  - Byte3 bits[3:0] are the signed wheel delta and drive `wheel_z` when the packet is applied.
  - Byte3 bits[7:4] are ignored.
  - Timeout and abort rules cover `WAIT_B3`.
- Undefined: 3-byte packets only. `WAIT_B3` is absent and `wheel_z` is tied to 0.

## Test plan

- **Reset and basic move:** after reset, send 0x09, 0x0A, 0x05 → `pkt_valid` pulses once; `mouse_x=330`, `mouse_y=235`, `left_click=1`, `right_click=0`.
- **Negative move and clamp:** from reset, send 0x18, 0xF6, 0x00 → `mouse_x=310`. Then send 0x08, 0x7F, 0x00 three times → `mouse_x=639`. Then send 0x08, 0x00, 0x7F twice → `mouse_y=0`.
- **Resync:** send 0x00, then 0x08, 0x01, 0x01 → one `sync_err` pulse, then `pkt_valid` with `mouse_x=321`, `mouse_y=239`.
- **Timeout:** send 0x08, 0x05, idle for `TIMEOUT_CYCLES`, then send 0x08, 0x01, 0x01 → `sync_err` pulses; the subsequent packet yields `mouse_x=321`, `mouse_y=239`.
- **Overflow and frame_err:**
  - Send 0x48, 0x10, 0x10 → `mouse_x` unchanged, `mouse_y` decreases by 16.
  - Send 0x08 with `frame_err` in the same cycle → `sync_err` pulses, state stays `WAIT_B0`.
- **Wheel (macro defined):** send 0x08, 0x00, 0x00, 0x0F → `wheel_z=4'hF` (-1); `pkt_valid` pulses only after the 4th byte.
